obstacle_sequencer: RTL and testbench
=====================================

// Module: obstacle_sequencer
// PURPOSE
//  Parametrised sequencer and multiplexer for N_OBS obstacle generators in the game pipeline.
//  Picks the next obstacle in round-robin or pseudo-random order and runs it until its done.
//  Then inserts a programmable gap, counts completed obstacles and muxes the active {x,y,rgb}.
//  Timing signals are delayed to stay aligned with the registered obstacle data.
//  Sits between the obstacle generators and the collision/draw stages.
// PARAMETERS
//  N_OBS       8       number of obstacle generators, 2..15
//  CODE_W      4       obstacle code width; 2**CODE_W > N_OBS
//  RAND_MODE   0       0 = round-robin 0..N_OBS-1; 1 = LFSR order, no immediate repeat
//  GAP_CYCLES  0       idle cycles between obstacles, 0..2**24-1
//  LFSR_SEED   16'hACE1 reset seed of the 16-bit LFSR; must be non-zero
//  SIG_DEL     1       delay of the timing bus; >=1, defaults to the data-path latency
// PORTS
//  clk                 in   1        pixel clock
//  rst                 in   1        synchronous, active-high reset
//  hcount_in, vcount_in in  12 each  raster position
//  hsync_in, hblnk_in, vsync_in, vblnk_in  in  1 each  raster timing
//  rgb_in              in   12       background pixel
//  game_on             in   1        level; low forces IDLE
//  play_selected       in   1        start request; rising edge is detected internally
//  victory             in   1        level; ends the run
//  obs_bus             in   36*N_OBS {x[11:0],y[11:0],rgb[11:0]} per obstacle; obstacle i at [36*i+:36]
//  obs_done            in   N_OBS    per-obstacle completion flags
//  obstacle_code       out  CODE_W   active obstacle; all-ones = none
//  done_out            out  1        1-cycle pulse; generators return to their idle state on it
//  obstacles_counted   out  16       binary count of completed obstacles, saturating
//  obstacle_data       out  36       registered {x,y,rgb} of the active obstacle
//  delayed_signals     out  28       {vcount,vsync,vblnk,hcount,hsync,hblnk} delayed by SIG_DEL
// BEHAVIOUR
//  Reset: state = IDLE; obstacle_code = all-ones; done_out = 0; obstacles_counted = 0.
//   obstacle_data = 0; delayed_signals pipeline = 0; LFSR = LFSR_SEED; last_code = all-ones.
//  FSM IDLE -> SELECT -> ACTIVE -> GAP -> SELECT.
//  IDLE: code = all-ones.
//   A rising edge of play_selected while game_on=1 clears the counter and goes to SELECT.
//  SELECT (round-robin): code = (last_code + 1) mod N_OBS; all-ones wraps to 0. Takes 1 cycle.
//  SELECT (LFSR): LFSR steps every cycle in SELECT; candidate = lfsr[CODE_W-1:0].
//   The candidate is rejected, and SELECT held, if candidate >= N_OBS or candidate == last_code.
//   Otherwise it is accepted.
//  ACTIVE: only obs_done[code] is honoured; all other done bits are ignored.
//   On obs_done[code]: count+1, saturating at 16'hFFFF; done_out=1 for 1 cycle; -> GAP.
//  GAP: code = all-ones; counts GAP_CYCLES cycles, then -> SELECT.
//   With GAP_CYCLES=0, GAP lasts 1 cycle.
//  victory=1 or game_on=0 in any state: -> IDLE next cycle; count held; done_out=1 for 1 cycle.
//   These exits override an obs_done in the same cycle; that obstacle is not counted.
//  play_selected rising edge in a non-IDLE state: ignored.
//  Data path: obstacle_data <= (code valid) ? obs_bus[36*code+:36] : {24'h0, rgb_in}.
//   Latency is 1 cycle. delayed_signals lags the inputs by SIG_DEL cycles.
//  Reset mid-run: all outputs return to their reset values on the next edge.
// STRUCTURE
//  obstacle_pkg: FSM state enum; IDLE_CODE; field widths X_W=Y_W=RGB_W=12; OBS_W=36; SIG_W=28.
//  Sub-module obstacle_lfsr: 16-bit Fibonacci LFSR, taps 16,14,13,11, enable and seed.
//  Reuse the existing delay module for the timing bus (WIDTH=28, CLK_DEL=SIG_DEL).
// TESTING
//  1. Reset, then play_selected edge, RAND_MODE=0, N_OBS=3, GAP_CYCLES=2
//     -> codes 0,1,2,0; code all-ones for 2 cycles between each; count 1,2,3,4.
//  2. In ACTIVE code=1: obs_done=3'b101 -> no transition; then obs_done=3'b010
//     -> done_out pulse, count+1.
//  3. RAND_MODE=1, N_OBS=5: 200 obstacles -> every code <5, never two equal in a row, all 5 seen.
//  4. victory and obs_done[code] in the same cycle -> IDLE, count unchanged, single done_out pulse.
//  5. Count preloaded near 16'hFFFE; 3 completions -> counter holds 16'hFFFF.
//  6. obs_bus[36*2+:36]=36'h123_456_789, code=2 -> obstacle_data matches 1 cycle later.
//     IDLE -> {24'h0, rgb_in} with rgb_in from the previous cycle.
//     hsync edge appears on delayed_signals SIG_DEL cycles later.

Source files
------------

// File: rtl/obstacle_pkg.sv
// Shared types and field widths for the obstacle sequencer slice.
package obstacle_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SELECT,
        S_ACTIVE,
        S_GAP
    } seq_state_t;

    localparam int X_W   = 12;
    localparam int Y_W   = 12;
    localparam int RGB_W = 12;
    localparam int OBS_W = X_W + Y_W + RGB_W;
    localparam int SIG_W = 28;

    // Truncated to CODE_W by each user; all-ones means "no obstacle".
    localparam logic [15:0] IDLE_CODE = 16'hFFFF;

    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/delay.sv
// Generic register pipeline delaying a bus by CLK_DEL cycles, cleared on reset.
module delay #(
    parameter int WIDTH   = 28,
    parameter int CLK_DEL = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] pipe [CLK_DEL];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < CLK_DEL; i++) begin
                pipe[i] <= '0;
            end
        end else begin
            pipe[0] <= din;
            for (int i = 1; i < CLK_DEL; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    assign dout = pipe[CLK_DEL-1];

endmodule

// File: rtl/obstacle_lfsr.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11) that advances only while enabled.
module obstacle_lfsr #(
    parameter logic [15:0] SEED  = 16'hACE1,
    parameter int          OUT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    output logic [OUT_W-1:0] value
);

    logic [15:0] lfsr_q;
    logic        feedback;

    assign feedback = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
    assign value    = lfsr_q[OUT_W-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= SEED;
        end else if (enable) begin
            lfsr_q <= {lfsr_q[14:0], feedback};
        end
    end

endmodule

// File: rtl/obstacle_sequencer.sv
// Picks obstacles in round-robin or LFSR order, runs each until done, inserts a gap,
// counts completions and muxes the active obstacle's {x,y,rgb} with aligned timing.
module obstacle_sequencer
    import obstacle_pkg::*;
#(
    parameter int          N_OBS      = 8,
    parameter int          CODE_W     = 4,
    parameter int          RAND_MODE  = 0,
    parameter int          GAP_CYCLES = 0,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1,
    parameter int          SIG_DEL    = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [11:0]            hcount_in,
    input  logic [11:0]            vcount_in,
    input  logic                   hsync_in,
    input  logic                   hblnk_in,
    input  logic                   vsync_in,
    input  logic                   vblnk_in,
    input  logic [RGB_W-1:0]       rgb_in,
    input  logic                   game_on,
    input  logic                   play_selected,
    input  logic                   victory,
    input  logic [OBS_W*N_OBS-1:0] obs_bus,
    input  logic [N_OBS-1:0]       obs_done,
    output logic [CODE_W-1:0]      obstacle_code,
    output logic                   done_out,
    output logic [15:0]            obstacles_counted,
    output logic [OBS_W-1:0]       obstacle_data,
    output logic [SIG_W-1:0]       delayed_signals
);

    localparam logic [CODE_W-1:0] NONE     = CODE_W'(IDLE_CODE);
    localparam logic [CODE_W-1:0] LAST_OBS = CODE_W'(N_OBS - 1);
    localparam logic [23:0]       GAP_LAST = (GAP_CYCLES == 0) ? 24'd0 : 24'(GAP_CYCLES - 1);
    localparam bit                USE_LFSR = (RAND_MODE != 0);

    seq_state_t        state_q, state_d;
    logic [CODE_W-1:0] code_q, code_d;
    logic [CODE_W-1:0] last_code_q, last_code_d;
    logic [CODE_W-1:0] rr_code, cand;
    logic [23:0]       gap_q, gap_d;
    logic [15:0]       count_q, count_next;
    logic              done_q, done_d;
    logic              play_q, play_edge;
    logic              start, abort, hit, cand_ok, inc, clear;
    logic              code_valid, sel_done;
    logic [OBS_W-1:0]  sel_obs, data_q;

    assign play_edge  = play_selected && !play_q;
    assign start      = (state_q == S_IDLE) && game_on && play_edge;
    assign abort      = (state_q != S_IDLE) && (victory || !game_on);
    assign code_valid = (code_q <= LAST_OBS);
    assign hit        = (state_q == S_ACTIVE) && sel_done;
    assign rr_code    = (last_code_q >= LAST_OBS) ? '0 : last_code_q + CODE_W'(1);
    assign cand_ok    = (cand <= LAST_OBS) && (cand != last_code_q);

    obstacle_lfsr #(
        .SEED  (LFSR_SEED),
        .OUT_W (CODE_W)
    ) u_lfsr (
        .clk    (clk),
        .rst    (rst),
        .enable (state_q == S_SELECT),
        .value  (cand)
    );

    // Loop-based select keeps the index width independent of N_OBS.
    always_comb begin
        sel_obs  = '0;
        sel_done = 1'b0;
        for (int i = 0; i < N_OBS; i++) begin
            if (code_q == CODE_W'(i)) begin
                sel_obs  = obs_bus[OBS_W*i +: OBS_W];
                sel_done = obs_done[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) state_d = S_SELECT;
            end
            S_SELECT: begin
                if (abort)                      state_d = S_IDLE;
                else if (!USE_LFSR || cand_ok)  state_d = S_ACTIVE;
            end
            S_ACTIVE: begin
                if (abort)    state_d = S_IDLE;
                else if (hit) state_d = S_GAP;
            end
            S_GAP: begin
                if (abort)                  state_d = S_IDLE;
                else if (gap_q >= GAP_LAST) state_d = S_SELECT;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Aborts take priority over a same-cycle completion: one pulse, no count.
    always_comb begin
        code_d      = code_q;
        last_code_d = last_code_q;
        gap_d       = '0;
        done_d      = abort || hit;
        inc         = hit && !abort;
        clear       = start;
        unique case (state_d)
            S_IDLE, S_GAP: code_d = NONE;
            S_SELECT:      code_d = USE_LFSR ? NONE : rr_code;
            S_ACTIVE: begin
                if (state_q == S_SELECT) begin
                    code_d      = USE_LFSR ? cand : code_q;
                    last_code_d = code_d;
                end
            end
            default: code_d = NONE;
        endcase
        if ((state_q == S_GAP) && (state_d == S_GAP)) begin
            gap_d = gap_q + 24'd1;
        end
    end

    assign count_next = clear ? 16'd0 : (inc ? sat_inc16(count_q) : count_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            code_q      <= NONE;
            last_code_q <= NONE;
            gap_q       <= '0;
            count_q     <= '0;
            done_q      <= 1'b0;
            play_q      <= 1'b0;
            data_q      <= '0;
        end else begin
            code_q      <= code_d;
            last_code_q <= last_code_d;
            gap_q       <= gap_d;
            count_q     <= count_next;
            done_q      <= done_d;
            play_q      <= play_selected;
            data_q      <= code_valid ? sel_obs : {{(X_W + Y_W){1'b0}}, rgb_in};
        end
    end

    delay #(
        .WIDTH   (SIG_W),
        .CLK_DEL (SIG_DEL)
    ) u_sig_delay (
        .clk  (clk),
        .rst  (rst),
        .din  ({vcount_in, vsync_in, vblnk_in, hcount_in, hsync_in, hblnk_in}),
        .dout (delayed_signals)
    );

    assign obstacle_code     = code_q;
    assign done_out          = done_q;
    assign obstacles_counted = count_q;
    assign obstacle_data     = data_q;

endmodule

// File: tb/tb_obstacle_sequencer.sv
// Directed bench: round-robin vector table plus hand sequences for data path,
// saturation, reset and an LFSR-order instance.
module tb_obstacle_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] hcount_in = '0, vcount_in = '0;
    logic        hsync_in = 1'b0, hblnk_in = 1'b0, vsync_in = 1'b0, vblnk_in = 1'b0;
    logic [11:0] rgb_in = '0;

    logic         game_on = 1'b0, play_selected = 1'b0, victory = 1'b0;
    logic [107:0] obs_bus = '0;
    logic [2:0]   obs_done = '0;
    logic [3:0]   obstacle_code;
    logic         done_out;
    logic [15:0]  obstacles_counted;
    logic [35:0]  obstacle_data;
    logic [27:0]  delayed_signals;

    logic         game_on_r = 1'b0, play_r = 1'b0;
    logic [179:0] obs_bus_r = '0;
    logic [4:0]   obs_done_r;
    logic [3:0]   code_r;
    logic         done_r;
    logic [15:0]  count_r;
    logic [35:0]  data_r;
    logic [27:0]  delayed_r;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        game_on;
        logic        play;
        logic        victory;
        logic [2:0]  done;
        logic [3:0]  code;
        logic        done_out;
        logic [15:0] count;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    obstacle_sequencer #(
        .N_OBS(3), .CODE_W(4), .RAND_MODE(0), .GAP_CYCLES(2), .LFSR_SEED(16'hACE1), .SIG_DEL(2)
    ) dut (
        .clk(clk), .rst(rst),
        .hcount_in(hcount_in), .vcount_in(vcount_in),
        .hsync_in(hsync_in), .hblnk_in(hblnk_in), .vsync_in(vsync_in), .vblnk_in(vblnk_in),
        .rgb_in(rgb_in), .game_on(game_on), .play_selected(play_selected), .victory(victory),
        .obs_bus(obs_bus), .obs_done(obs_done),
        .obstacle_code(obstacle_code), .done_out(done_out), .obstacles_counted(obstacles_counted),
        .obstacle_data(obstacle_data), .delayed_signals(delayed_signals)
    );

    obstacle_sequencer #(
        .N_OBS(5), .CODE_W(4), .RAND_MODE(1), .GAP_CYCLES(0), .LFSR_SEED(16'hACE1), .SIG_DEL(1)
    ) dut_rand (
        .clk(clk), .rst(rst),
        .hcount_in(hcount_in), .vcount_in(vcount_in),
        .hsync_in(hsync_in), .hblnk_in(hblnk_in), .vsync_in(vsync_in), .vblnk_in(vblnk_in),
        .rgb_in(rgb_in), .game_on(game_on_r), .play_selected(play_r), .victory(1'b0),
        .obs_bus(obs_bus_r), .obs_done(obs_done_r),
        .obstacle_code(code_r), .done_out(done_r), .obstacles_counted(count_r),
        .obstacle_data(data_r), .delayed_signals(delayed_r)
    );

    // The randomly-ordered generators finish as soon as they are selected.
    always_comb begin
        obs_done_r = '0;
        if (code_r < 4'd5) obs_done_r = 5'b00001 << code_r;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [35:0] actual, input logic [35:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        game_on       = v.game_on;
        play_selected = v.play;
        victory       = v.victory;
        obs_done      = v.done;
        tick();
    endtask

    task automatic addVec(input logic g, input logic p, input logic v, input logic [2:0] d,
                          input logic [3:0] c, input logic dn, input logic [15:0] n);
        vec_t t;
        t.game_on = g; t.play = p; t.victory = v; t.done = d;
        t.code = c; t.done_out = dn; t.count = n;
        vecs.push_back(t);
    endtask

    task automatic autoDone();
        obs_done = (obstacle_code < 4'd3) ? (3'b001 << obstacle_code) : 3'b000;
    endtask

    task automatic waitCode(input logic [3:0] target, input int budget);
        int n;
        n = 0;
        while (obstacle_code != target && n < budget) begin
            autoDone();
            tick();
            n++;
        end
        obs_done = '0;
        if (obstacle_code != target) begin
            checks++;
            errors++;
            $display("[TB] FAIL wait_code: got %0h expected %0h", obstacle_code, target);
        end
    endtask

    task automatic completeOne(input int budget);
        int n;
        n = 0;
        do begin
            autoDone();
            tick();
            n++;
        end while (!done_out && n < budget);
        obs_done = '0;
        if (!done_out) begin
            checks++;
            errors++;
            $display("[TB] FAIL complete_timeout: got done_out %0d expected 1", done_out);
        end
    endtask

    int         n_obs;
    int         last_obs;
    int         cyc;
    logic [4:0] seen;
    logic [3:0] prev_code;

    initial begin
        // game_on, play, victory, obs_done -> code, done_out, count
        addVec(1,1,0,3'b000, 4'h0,0,16'd0);
        addVec(1,1,0,3'b000, 4'h0,0,16'd0);
        addVec(1,1,0,3'b001, 4'hF,1,16'd1);
        addVec(1,1,0,3'b000, 4'hF,0,16'd1);
        addVec(1,1,0,3'b000, 4'h1,0,16'd1);
        addVec(1,1,0,3'b000, 4'h1,0,16'd1);
        addVec(1,1,0,3'b101, 4'h1,0,16'd1);
        addVec(1,1,0,3'b010, 4'hF,1,16'd2);
        addVec(1,1,0,3'b000, 4'hF,0,16'd2);
        addVec(1,1,0,3'b000, 4'h2,0,16'd2);
        addVec(1,1,0,3'b000, 4'h2,0,16'd2);
        addVec(1,1,0,3'b100, 4'hF,1,16'd3);
        addVec(1,1,0,3'b000, 4'hF,0,16'd3);
        addVec(1,1,0,3'b000, 4'h0,0,16'd3);
        addVec(1,1,0,3'b000, 4'h0,0,16'd3);
        addVec(1,1,0,3'b001, 4'hF,1,16'd4);
        addVec(1,1,0,3'b000, 4'hF,0,16'd4);
        addVec(1,1,0,3'b000, 4'h1,0,16'd4);
        addVec(1,1,0,3'b000, 4'h1,0,16'd4);
        addVec(1,1,1,3'b010, 4'hF,1,16'd4);
        addVec(1,1,0,3'b000, 4'hF,0,16'd4);
        addVec(1,1,0,3'b010, 4'hF,0,16'd4);
        addVec(1,0,0,3'b000, 4'hF,0,16'd4);
        addVec(1,1,0,3'b000, 4'h2,0,16'd0);
        addVec(1,0,0,3'b000, 4'h2,0,16'd0);
        addVec(1,1,0,3'b000, 4'h2,0,16'd0);
        addVec(0,1,0,3'b000, 4'hF,1,16'd0);
        addVec(0,0,0,3'b000, 4'hF,0,16'd0);

        tick();
        tick();
        checkOutput("reset code", 36'(obstacle_code), 36'hF);
        checkOutput("reset done", 36'(done_out), 36'h0);
        checkOutput("reset count", 36'(obstacles_counted), 36'h0);
        checkOutput("reset data", obstacle_data, 36'h0);
        checkOutput("reset delayed", 36'(delayed_signals), 36'h0);

        rst = 1'b0;
        game_on = 1'b1;
        tick();

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("vec%0d code", i), 36'(obstacle_code), 36'(vecs[i].code));
            checkOutput($sformatf("vec%0d done", i), 36'(done_out), 36'(vecs[i].done_out));
            checkOutput($sformatf("vec%0d count", i), 36'(obstacles_counted), 36'(vecs[i].count));
        end

        // Data mux: previous obstacle code was 2, so the run restarts at 0.
        obs_bus[0  +: 36] = 36'hFEDCBA987;
        obs_bus[36 +: 36] = 36'h0F0F0F0F0;
        obs_bus[72 +: 36] = 36'h123456789;
        game_on = 1'b1;
        play_selected = 1'b0;
        tick();
        play_selected = 1'b1;
        tick();
        checkOutput("data start code", 36'(obstacle_code), 36'h0);
        tick();
        checkOutput("data slot0", obstacle_data, 36'hFEDCBA987);
        waitCode(4'h2, 50);
        tick();
        checkOutput("data code2", 36'(obstacle_code), 36'h2);
        checkOutput("data slot2", obstacle_data, 36'h123456789);

        game_on = 1'b0;
        tick();
        checkOutput("abort done", 36'(done_out), 36'h1);
        rgb_in = 12'hABC;
        tick();
        checkOutput("idle rgb abc", obstacle_data, 36'h000000ABC);
        rgb_in = 12'h5A5;
        tick();
        checkOutput("idle rgb 5a5", obstacle_data, 36'h0000005A5);

        hsync_in = 1'b1; hblnk_in = 1'b1; vsync_in = 1'b1; vblnk_in = 1'b0;
        hcount_in = 12'h321; vcount_in = 12'h654;
        tick();
        checkOutput("hsync after 1", 36'(delayed_signals[1]), 36'h0);
        tick();
        checkOutput("delayed bus", 36'(delayed_signals), 36'({12'h654, 1'b1, 1'b0, 12'h321, 1'b1, 1'b1}));

        // Saturation: preload the counter through its next-value net.
        game_on = 1'b1;
        play_selected = 1'b0;
        tick();
        play_selected = 1'b1;
        tick();
        tick();
        force dut.count_next = 16'hFFFE;
        tick();
        release dut.count_next;
        checkOutput("preload", 36'(obstacles_counted), 36'hFFFE);
        for (int k = 0; k < 3; k++) begin
            completeOne(40);
            checkOutput($sformatf("saturate%0d", k), 36'(obstacles_counted), 36'hFFFF);
        end

        rst = 1'b1;
        tick();
        checkOutput("midrun rst code", 36'(obstacle_code), 36'hF);
        checkOutput("midrun rst count", 36'(obstacles_counted), 36'h0);
        checkOutput("midrun rst data", obstacle_data, 36'h0);
        checkOutput("midrun rst delayed", 36'(delayed_signals), 36'h0);
        rst = 1'b0;
        game_on = 1'b0;

        // LFSR order: range, no immediate repeat, full coverage.
        game_on_r = 1'b1;
        play_r = 1'b1;
        n_obs = 0;
        last_obs = -1;
        cyc = 0;
        seen = '0;
        prev_code = 4'hF;
        while (n_obs < 200 && cyc < 20000) begin
            tick();
            cyc++;
            if (code_r != 4'hF && prev_code == 4'hF) begin
                checks++;
                if (code_r >= 4'd5) begin
                    errors++;
                    $display("[TB] FAIL rand range: got %0d expected <5", code_r);
                end else begin
                    seen[code_r[2:0]] = 1'b1;
                end
                if (last_obs >= 0) begin
                    checks++;
                    if (int'(code_r) == last_obs) begin
                        errors++;
                        $display("[TB] FAIL rand repeat: got %0d expected not %0d", code_r, last_obs);
                    end
                end
                last_obs = int'(code_r);
                n_obs++;
            end
            prev_code = code_r;
        end
        checkOutput("rand obstacles", 36'(n_obs), 36'd200);
        checkOutput("rand all seen", 36'(seen), 36'h1F);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
